pool2d_stream: RTL and testbench
================================

Name: pool2d_stream

Overview:
- Streaming successor to the frame-array max-pool layer.
- Consumes one feature-map pixel per valid/ready handshake, in channel-major raster order (ch, row, col).
- Applies a non-overlapping POOL×POOL window, selectable per frame as max or average, and emits pooled pixels on a valid/ready output stream.
- Sits between conv/ReLU stream stages and the dense layer; a single line of accumulators replaces full-frame storage.

Parameters:
- DATA_WIDTH, 16, signed pixel width (in and out).
- CHANNELS, 8, feature maps per frame.
- IN_SIZE, 28, input height = width; must be a multiple of POOL.
- POOL, 2, window size = stride; power of two, ≥2.
- OUT_SIZE (localparam), IN_SIZE/POOL.
- ACC_W (localparam), DATA_WIDTH + 2*$clog2(POOL), accumulator width.

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous, active-high.
- start, in, 1, begin a frame; sampled only in IDLE.
- mode, in, 1, pool_mode_t (0 = MAX, 1 = AVG); latched on accepted start.
- in_valid, in, 1, input pixel valid.
- in_ready, out, 1, input pixel accepted when in_valid && in_ready.
- in_data, in, DATA_WIDTH, signed input pixel.
- out_valid, out, 1, pooled pixel valid.
- out_ready, in, 1, downstream accepts.
- out_data, out, DATA_WIDTH, signed pooled pixel.
- out_last, out, 1, marks final pooled pixel of the frame.
- busy, out, 1, high in any state except IDLE.
- done, out, 1, one-cycle pulse at frame completion.

Behaviour:
- Clock and reset: clk; reset is synchronous, active-high. Reset values: state IDLE; in_ready, out_valid, out_last, done, busy = 0; out_data = 0; counters ch/r/c = 0. Reset mid-frame abandons the frame; accumulators need not be cleared.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE: on start, latch mode, clear counters, go to RUN. start is ignored in every other state.
  - RUN: in_ready = !out_valid || out_ready. Input stalls whole-stream while an output is held.
    - When the frame's last input pixel (ch=CHANNELS-1, r=c=IN_SIZE-1) is accepted, go to DRAIN.
  - DRAIN: in_ready = 0. On the out_valid && out_ready handshake, go to DONE.
  - DONE: done = 1 for exactly one cycle, then IDLE. done is high the cycle after the final output handshake.
- Counters per accepted pixel: c increments; wraps to 0 at IN_SIZE-1 and increments r. r wraps at IN_SIZE-1 and increments ch.
- Accumulation: oc = c/POOL.
  - First pixel of a window (r%POOL==0 && c%POOL==0): acc[oc] = sign-extended in_data.
  - Otherwise: MAX mode acc[oc] = signed max(acc[oc], in_data); AVG mode acc[oc] = acc[oc] + in_data.
  - Window-closing pixel (r%POOL==POOL-1 && c%POOL==POOL-1): include it in the result, and on the next cycle set out_valid = 1 with out_data.
    - MAX: out_data = the max.
    - AVG: out_data = (full sum) >>> 2*$clog2(POOL), arithmetic shift (floor), truncated to DATA_WIDTH; no overflow is possible.
  - out_last = 1 with the final window of the frame.
- Latency: exactly 1 cycle from accepting a window-closing pixel to out_valid.
- Output hold: out_valid, out_data and out_last hold stable until out_ready. If out_ready and a new window-closing pixel are accepted in the same cycle, the register reloads back-to-back with no bubble.
- Output count per frame: CHANNELS*OUT_SIZE*OUT_SIZE, in (ch, orow, ocol) order.
- Simultaneous start and reset: reset wins.

Decomposition:
- Shared package cnn_pkg:
  - typedef enum logic {POOL_MAX, POOL_AVG} pool_mode_t;
  - typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} pool_state_t;
- Sub-module pool_line_acc: owns acc[0:OUT_SIZE-1]. Interface: index, first, mode, data in; combined result out.
- The top level holds the FSM, counters and the output register.

Test Plan:
1. MAX, IN_SIZE=4, POOL=2, CHANNELS=1, input 0..15 raster, out_ready=1 -> outputs 5,7,13,15; out_last on 15; done one cycle after 4th handshake.
2. AVG, 2×2 window {-1,-2,-3,-4} -> -3 (floor of -2.5); window {1,2,3,5} -> 2; window {32767 ×4} -> 32767.
3. Backpressure: out_ready held low 5 cycles while an output is pending -> in_ready=0 throughout, no pixel lost or duplicated, out_data stable.
4. POOL=4, IN_SIZE=8, CHANNELS=2, MAX with one spike of 100 per window -> 8 outputs all 100; done exactly once.
5. Reset asserted mid-RUN after 37 pixels -> next cycle state IDLE, out_valid=0, busy=0; a fresh frame then produces correct results.
6. Default params, random data, random in_valid/out_ready -> 1568 outputs match golden model; start pulsed during RUN is ignored.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types for the CNN streaming layers: pooling mode and pool FSM states.
// No logic; types only.
// Imported by the pooling block, its accumulator line and the testbench.
package cnn_pkg;

  typedef enum logic {
    POOL_MAX,
    POOL_AVG
  } pool_mode_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } pool_state_t;

endpackage

// File: rtl/pool2d_stream_if.sv
// Pixel-in / pooled-pixel-out stream bundle for pool2d_stream.
// No logic; the handshake timing belongs to the endpoints.
// Both streams are valid/ready; a transfer happens when valid && ready.
interface pool2d_stream_if #(
  parameter int DATA_WIDTH = 16
);

  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] in_data;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] out_data;
  logic                         out_last;

  // Upstream/downstream side (drives pixels, accepts pooled results).
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  // Pooling block side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/pool_line_acc.sv
// One row of window accumulators, one per pooled output column.
// Result is combinational from the current accumulator and the incoming pixel.
// No flow control; the caller strobes wr_en only on accepted pixels.
module pool_line_acc
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_W      = 18,
  parameter int OUT_SIZE   = 14,
  parameter int IDX_W      = 4
) (
  input  logic                         clk,
  input  logic                         wr_en,
  input  logic [IDX_W-1:0]             idx,
  input  logic                         first,
  input  pool_mode_t                   mode,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic signed [ACC_W-1:0]      result
);

  logic signed [ACC_W-1:0] acc_q [OUT_SIZE];
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] acc_cur;
  logic signed [ACC_W-1:0] data_ext;

  // Fold the incoming pixel into its column's window (restart on the window's first pixel).
  always_comb begin
    data_ext = ACC_W'(data_in);
    acc_cur  = acc_q[idx];
    acc_d    = data_ext;
    if (!first) begin
      if (mode == POOL_AVG) begin
        acc_d = acc_cur + data_ext;
      end else begin
        acc_d = (data_ext > acc_cur) ? data_ext : acc_cur;
      end
    end
  end

  // Store the updated window value; contents are meaningless until rewritten by a first pixel.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      acc_q[idx] <= acc_d;
    end
  end

  assign result = acc_d;

endmodule

// File: rtl/pool2d_stream.sv
// Streaming non-overlapping POOLxPOOL max/avg pooling over channel-major raster pixels.
// Pooled pixel is valid one cycle after its window-closing input pixel is accepted.
// Any held output stalls the whole input stream (in_ready drops until out_ready).
module pool2d_stream
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 8,
  parameter int IN_SIZE    = 28,
  parameter int POOL       = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  pool_mode_t     mode,
  pool2d_stream_if.slave s,
  output logic           busy,
  output logic           done
);

  localparam int OUT_SIZE = IN_SIZE / POOL;
  localparam int SHIFT    = $clog2(POOL);
  localparam int ACC_W    = DATA_WIDTH + 2 * SHIFT;
  localparam int CW       = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
  localparam int CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int IDX_W    = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;

  localparam logic [CW-1:0]  POS_MAX = CW'(IN_SIZE - 1);
  localparam logic [CHW-1:0] CH_MAX  = CHW'(CHANNELS - 1);

  pool_state_t state_q, state_d;
  pool_mode_t  mode_q, mode_d;
  logic [CW-1:0]  c_q, c_d, r_q, r_d;
  logic [CHW-1:0] ch_q, ch_d;

  logic                         out_valid_q, out_valid_d;
  logic                         out_last_q, out_last_d;
  logic signed [DATA_WIDTH-1:0] out_data_q, out_data_d;

  logic                    in_ready;
  logic                    accept;
  logic                    out_fire;
  logic                    win_first;
  logic                    win_close;
  logic                    frame_last;
  logic [IDX_W-1:0]        oc;
  logic signed [ACC_W-1:0] acc_res;
  logic signed [ACC_W-1:0] avg_res;

  // Handshake qualifiers and position of the current pixel inside its window.
  always_comb begin
    in_ready   = (state_q == RUN) && (!out_valid_q || s.out_ready);
    accept     = s.in_valid && in_ready;
    out_fire   = out_valid_q && s.out_ready;
    win_first  = (r_q[SHIFT-1:0] == '0) && (c_q[SHIFT-1:0] == '0);
    win_close  = (&r_q[SHIFT-1:0]) && (&c_q[SHIFT-1:0]);
    frame_last = (ch_q == CH_MAX) && (r_q == POS_MAX) && (c_q == POS_MAX);
    oc         = IDX_W'(c_q >> SHIFT);
  end

  pool_line_acc #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_W      (ACC_W),
    .OUT_SIZE   (OUT_SIZE),
    .IDX_W      (IDX_W)
  ) u_acc (
    .clk     (clk),
    .wr_en   (accept),
    .idx     (oc),
    .first   (win_first),
    .mode    (mode_q),
    .data_in (s.in_data),
    .result  (acc_res)
  );

  // Output register: hold until taken, reload when a window closes (same cycle as a take is fine).
  always_comb begin
    avg_res     = acc_res >>> (2 * SHIFT);
    out_valid_d = out_valid_q && !s.out_ready;
    out_last_d  = out_last_q && !out_fire;
    out_data_d  = out_data_q;
    if (accept && win_close) begin
      out_valid_d = 1'b1;
      out_last_d  = frame_last;
      out_data_d  = (mode_q == POOL_AVG) ? avg_res[DATA_WIDTH-1:0] : acc_res[DATA_WIDTH-1:0];
    end
  end

  // Frame sequencing and raster counters (col fastest, then row, then channel).
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    c_d     = c_q;
    r_d     = r_q;
    ch_d    = ch_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          mode_d  = mode;
          c_d     = '0;
          r_d     = '0;
          ch_d    = '0;
        end
      end
      RUN: begin
        if (accept) begin
          if (c_q == POS_MAX) begin
            c_d = '0;
            if (r_q == POS_MAX) begin
              r_d  = '0;
              ch_d = (ch_q == CH_MAX) ? '0 : ch_q + 1'b1;
            end else begin
              r_d = r_q + 1'b1;
            end
          end else begin
            c_d = c_q + 1'b1;
          end
          if (frame_last) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (out_fire) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any frame in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mode_q      <= POOL_MAX;
      c_q         <= '0;
      r_q         <= '0;
      ch_q        <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      c_q         <= c_d;
      r_q         <= r_d;
      ch_q        <= ch_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  assign s.in_ready  = in_ready;
  assign s.out_valid = out_valid_q;
  assign s.out_data  = out_data_q;
  assign s.out_last  = out_last_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_pool2d_stream.sv
// Directed bench for pool2d_stream over three parameter sets:
// dut 0: 1ch 4x4 pool 2, dut 1: 2ch 8x8 pool 4, dut 2: default 8ch 28x28 pool 2.
// Inputs are driven after the falling edge; outputs are sampled 1 time unit later.
module tb_pool2d_stream;
  import cnn_pkg::*;

  localparam int NDUT   = 3;
  localparam int MAXPX  = 6272;
  localparam int MAXOUT = 1568;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst       [NDUT];
  logic               start     [NDUT];
  pool_mode_t         mode      [NDUT];
  logic               busy      [NDUT];
  logic               done      [NDUT];
  logic               in_valid  [NDUT];
  logic               in_ready  [NDUT];
  logic signed [15:0] in_data   [NDUT];
  logic               out_valid [NDUT];
  logic               out_ready [NDUT];
  logic signed [15:0] out_data  [NDUT];
  logic               out_last  [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int CH = (g == 0) ? 1 : (g == 1) ? 2 : 8;
    localparam int SZ = (g == 0) ? 4 : (g == 1) ? 8 : 28;
    localparam int PL = (g == 1) ? 4 : 2;

    pool2d_stream_if #(.DATA_WIDTH(16)) ifc ();

    assign ifc.in_valid  = in_valid[g];
    assign ifc.in_data   = in_data[g];
    assign ifc.out_ready = out_ready[g];
    assign in_ready[g]   = ifc.in_ready;
    assign out_valid[g]  = ifc.out_valid;
    assign out_data[g]   = ifc.out_data;
    assign out_last[g]   = ifc.out_last;

    pool2d_stream #(
      .DATA_WIDTH (16),
      .CHANNELS   (CH),
      .IN_SIZE    (SZ),
      .POOL       (PL)
    ) dut (
      .clk   (clk),
      .reset (rst[g]),
      .start (start[g]),
      .mode  (mode[g]),
      .s     (ifc),
      .busy  (busy[g]),
      .done  (done[g])
    );
  end

  int n_assert = 0;
  int n_fail   = 0;

  int                 fp     [NDUT];
  int                 px_n   [NDUT];
  logic signed [15:0] px     [NDUT][MAXPX];
  logic signed [15:0] exp_d  [MAXOUT];
  logic signed [15:0] cap_d  [MAXOUT];
  logic               cap_l  [MAXOUT];
  int cap_n, done_n, cyc, last_hs_cyc, done_cyc, first_ov_cyc;
  int vld_pct, rdy_pct, bp_left;
  bit bp_arm;
  logic signed [15:0] bp_dat;

  function automatic int sz_of(input int k);
    return (k == 0) ? 4 : (k == 1) ? 8 : 28;
  endfunction
  function automatic int ch_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : 8;
  endfunction
  function automatic int pl_of(input int k);
    return (k == 1) ? 4 : 2;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock of stimulus/observation for dut k, entered and left just after a falling edge.
  task automatic step(input int k);
    if (bp_arm && out_valid[k]) begin
      bp_arm  = 1'b0;
      bp_left = 5;
      bp_dat  = out_data[k];
    end
    in_valid[k]  = (fp[k] < px_n[k]) && ($urandom_range(99) < vld_pct);
    in_data[k]   = (fp[k] < px_n[k]) ? px[k][fp[k]] : 16'sd0;
    out_ready[k] = (bp_left == 0) && ($urandom_range(99) < rdy_pct);
    #1;
    if (bp_left > 0) begin
      chk("stall_in_ready", in_ready[k], 0);
      chk("stall_out_valid", out_valid[k], 1);
      chk("stall_out_data", out_data[k], bp_dat);
      bp_left--;
    end
    if (out_valid[k] && first_ov_cyc < 0) first_ov_cyc = cyc;
    if (in_valid[k] && in_ready[k]) fp[k]++;
    if (out_valid[k] && out_ready[k]) begin
      if (cap_n < MAXOUT) begin
        cap_d[cap_n] = out_data[k];
        cap_l[cap_n] = out_last[k];
      end
      cap_n++;
      last_hs_cyc = cyc;
    end
    if (done[k]) begin
      done_n++;
      done_cyc = cyc;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // Start a frame, feed every pixel, wait (bounded) for done, then idle a few cycles.
  task automatic run_frame(input int k, input pool_mode_t m, input int vp, input int rp, input int glitch_at);
    fp[k] = 0; cap_n = 0; done_n = 0; cyc = 0;
    last_hs_cyc = -1; done_cyc = -1; first_ov_cyc = -1;
    vld_pct = vp; rdy_pct = rp;
    start[k] = 1'b1; mode[k] = m;
    step(k);
    start[k] = 1'b0;
    while (done_n == 0 && cyc < 20000) begin
      if (cyc == glitch_at) begin
        start[k] = 1'b1;
        mode[k]  = (m == POOL_MAX) ? POOL_AVG : POOL_MAX;
      end else begin
        start[k] = 1'b0;
      end
      step(k);
    end
    start[k] = 1'b0;
    repeat (3) step(k);
    chk("done_pulses", done_n, 1);
    chk("pixels_accepted", fp[k], px_n[k]);
    chk("busy_after_frame", busy[k], 0);
  endtask

  task automatic check_outputs(input int n);
    chk("out_count", cap_n, n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("out_data[%0d]", i), cap_d[i], exp_d[i]);
      chk($sformatf("out_last[%0d]", i), cap_l[i], (i == n - 1) ? 1 : 0);
    end
  endtask

  // Whole-frame reference: pool each window straight from the stored input frame.
  task automatic golden(input int k, input pool_mode_t m);
    int sz, pl, os, sh, v, acc, o;
    sz = sz_of(k); pl = pl_of(k); os = sz / pl; sh = (pl == 4) ? 4 : 2; o = 0;
    for (int chn = 0; chn < ch_of(k); chn++)
      for (int orr = 0; orr < os; orr++)
        for (int occ = 0; occ < os; occ++) begin
          acc = 0;
          for (int wr = 0; wr < pl; wr++)
            for (int wc = 0; wc < pl; wc++) begin
              v = int'(px[k][chn*sz*sz + (orr*pl + wr)*sz + occ*pl + wc]);
              if (wr == 0 && wc == 0) acc = v;
              else if (m == POOL_AVG) acc += v;
              else if (v > acc) acc = v;
            end
          if (m == POOL_AVG) acc = acc >>> sh;
          exp_d[o] = 16'(acc);
          o++;
        end
  endtask

  initial begin
    int t2 [16];
    int v, w, pos;

    for (int k = 0; k < NDUT; k++) begin
      rst[k] = 1'b1; start[k] = 1'b0; mode[k] = POOL_MAX;
      in_valid[k] = 1'b0; in_data[k] = '0; out_ready[k] = 1'b0; fp[k] = 0;
      px_n[k] = sz_of(k) * sz_of(k) * ch_of(k);
    end
    bp_arm = 1'b0; bp_left = 0;

    // Reset state of every instance.
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) rst[k] = 1'b0;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      chk("rst_in_ready", in_ready[k], 0);
      chk("rst_out_valid", out_valid[k], 0);
      chk("rst_out_last", out_last[k], 0);
      chk("rst_out_data", out_data[k], 0);
      chk("rst_busy", busy[k], 0);
      chk("rst_done", done[k], 0);
    end
    @(negedge clk);

    // 1: MAX over 0..15 at full rate.
    for (int i = 0; i < 16; i++) px[0][i] = 16'(i);
    exp_d[0] = 5; exp_d[1] = 7; exp_d[2] = 13; exp_d[3] = 15;
    run_frame(0, POOL_MAX, 100, 100, -1);
    check_outputs(4);
    chk("t1_first_out_cycle", first_ov_cyc, 7);
    chk("t1_last_handshake_cycle", last_hs_cyc, 17);
    chk("t1_done_cycle", done_cyc, 18);

    // 2: AVG with negative floor, non-integer mean and both saturation corners.
    t2 = '{-1, -2, 1, 2,
           -3, -4, 3, 5,
           32767, 32767, -32768, -32768,
           32767, 32767, -32768, -32768};
    for (int i = 0; i < 16; i++) px[0][i] = 16'(t2[i]);
    exp_d[0] = -3; exp_d[1] = 2; exp_d[2] = 32767; exp_d[3] = -32768;
    run_frame(0, POOL_AVG, 60, 50, -1);
    check_outputs(4);

    // 3: first output held 5 cycles by out_ready low.
    for (int i = 0; i < 16; i++) px[0][i] = 16'(i);
    exp_d[0] = 5; exp_d[1] = 7; exp_d[2] = 13; exp_d[3] = 15;
    bp_arm = 1'b1;
    run_frame(0, POOL_MAX, 100, 100, -1);
    check_outputs(4);
    chk("t3_stall_consumed", bp_left, 0);

    // 4: POOL=4, one spike of 100 per 4x4 window among smaller values.
    for (int chn = 0; chn < 2; chn++)
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) begin
          w   = chn * 4 + (r / 4) * 2 + (c / 4);
          pos = (w * 5) % 16;
          v   = int'($urandom_range(599)) - 500;
          if ((r % 4) == pos / 4 && (c % 4) == pos % 4) v = 100;
          px[1][chn*64 + r*8 + c] = 16'(v);
        end
    for (int i = 0; i < 8; i++) exp_d[i] = 100;
    run_frame(1, POOL_MAX, 75, 65, -1);
    check_outputs(8);

    // 5: reset after 37 accepted pixels of a default-size frame.
    for (int i = 0; i < MAXPX; i++) px[2][i] = 16'($urandom);
    fp[2] = 0; cap_n = 0; done_n = 0; cyc = 0; first_ov_cyc = -1;
    vld_pct = 80; rdy_pct = 70;
    start[2] = 1'b1; mode[2] = POOL_MAX;
    step(2);
    start[2] = 1'b0;
    while (fp[2] < 37 && cyc < 500) step(2);
    chk("t5_pixels_before_reset", fp[2], 37);
    rst[2] = 1'b1;
    step(2);
    rst[2] = 1'b0;
    #1;
    chk("t5_busy", busy[2], 0);
    chk("t5_out_valid", out_valid[2], 0);
    chk("t5_out_last", out_last[2], 0);
    chk("t5_in_ready", in_ready[2], 0);
    chk("t5_out_data", out_data[2], 0);
    @(negedge clk);

    // 6: full default frame, random data and handshakes, stray start mid-frame.
    for (int i = 0; i < MAXPX; i++) px[2][i] = 16'($urandom);
    golden(2, POOL_AVG);
    run_frame(2, POOL_AVG, 70, 60, 500);
    check_outputs(MAXOUT);
    golden(2, POOL_MAX);
    run_frame(2, POOL_MAX, 100, 100, -1);
    check_outputs(MAXOUT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
